vis_frame_receiver: RTL and testbench
=====================================

Name: vis_frame_receiver

Overview:
- AXI4-Stream sink for the visibility stream emitted by the correlator top: ACCUM-bit re/im pairs with valid/ready/last.
- Captures complete frames of CORES*TRATE visibilities into a two-bank buffer and checks frame length.
- Exposes the oldest complete frame to a host-side register reader through a random-access read port with a release handshake.
- Sits on vis_clock between the correlator output and the host register/DMA logic.

Parameters:
ACCUM, 36, bit-width of each real/imag visibility
CORES, 18, correlator cores per frame slice
TRATE, 30, time-multiplexing rate; TOTAL = CORES*TRATE beats per frame (540)
ABITS, $clog2(CORES*TRATE) (10), local: frame address width
FBITS, 16, width of the good-frame counter

Ports:
vis_clock  in  1  clock
reset_n  in  1  synchronous, active-low reset
s_revis_i  in  ACCUM  stream real visibility
s_imvis_i  in  ACCUM  stream imag visibility
s_valid_i  in  1  stream beat valid
s_last_i  in  1  final beat of frame
s_ready_o  out  1  sink can accept beat
rd_req_i  in  1  read strobe
rd_addr_i  in  ABITS  visibility index within frame
rd_revis_o  out  ACCUM  read data, real
rd_imvis_o  out  ACCUM  read data, imag
rd_valid_o  out  1  read data valid
frame_avail_o  out  1  complete frame readable
frame_done_i  in  1  host releases current read frame
frame_count_o  out  FBITS  good frames received, wrapping
err_short_o  out  1  one-cycle pulse: last before TOTAL beats
err_long_o  out  1  one-cycle pulse: TOTAL beats without last

Behaviour:
- Reset (reset_n=0 at a vis_clock edge):
  - Both banks FREE; wbank=rbank=0; waddr=0; state FILL.
  - s_ready_o, rd_valid_o, frame_avail_o, err_* all 0; frame_count_o=0; rd_* data 0.
  - Reset mid-frame discards all stored data.
- s_ready_o is driven from flops only: 1 when reset_n was high on the previous edge, state FILL or DROP, and full[wbank]=0. No combinational path from s_valid_i.
- Beat accepted = s_valid_i & s_ready_o.
- FILL, accepted beat, waddr < TOTAL-1, last=0: write {wbank,waddr}; waddr++.
- FILL, accepted beat, waddr == TOTAL-1, last=1:
  - Write the beat; full[wbank]<=1; wbank toggles; waddr<=0; frame_count++.
  - If the other bank is FREE, ready stays 1 with no bubble.
- FILL, accepted last with waddr < TOTAL-1:
  - err_short_o pulses next cycle; waddr<=0; bank stays FREE; the partial frame is discarded.
- FILL, accepted beat, waddr == TOTAL-1, last=0:
  - err_long_o pulses; beat not stored; go to DROP.
- DROP: ready=1; accepted beats are discarded; accepted last -> waddr<=0, FILL.
- Both banks FULL: s_ready_o=0 (back-pressure) until a release.
- frame_avail_o = full[rbank] (registered state).
- Read port:
  - rd_req_i & frame_avail_o & rd_addr_i < TOTAL: data for {rbank,rd_addr_i} appears with rd_valid_o=1 one cycle later.
  - Otherwise rd_valid_o=0 and data holds.
- frame_done_i & frame_avail_o: full[rbank]<=0; rbank toggles.
  - frame_done_i without avail is ignored.
  - rd_req_i in the same cycle as frame_done_i reads the released bank (read issued before release).
- Simultaneous release of rbank and completion into wbank: both take effect in the same edge.
  - Ready remains 1 if the new wbank is the just-released bank.
- Counter wraps 2^FBITS-1 -> 0.
- Latency: last accepted beat -> frame_avail_o high on the next cycle when that bank becomes rbank.

Decomposition:
- Package tart_vis_pkg:
  - Default ACCUM/CORES/TRATE.
  - Derived TOTAL/ABITS function.
  - Receiver state enum {FILL, DROP}.
- One sub-module: vis_bank_ram.
  - Two-bank simple dual-port RAM, 2*TOTAL x 2*ACCUM.
  - Synchronous write; registered 1-cycle read.

Test Plan:
1. One frame, 540 beats, revis=i, imvis=-i, last on beat 540 -> frame_avail_o=1 the next cycle; frame_count_o=1; read addr 5 -> rd_revis_o=5, rd_imvis_o=-5, rd_valid_o=1 one cycle later.
2. Three back-to-back frames, no release -> frames 1-2 accepted without a ready bubble; s_ready_o=0 after beat 1080; frame_done_i pulse -> ready=1 the next cycle; frame 3 completes; reads return frame 2, then frame 3 after a second release.
3. Last on beat 100 -> err_short_o single pulse; frame_avail_o stays 0; count unchanged; the following 540-beat frame succeeds and reads addr 0 correctly.
4. 545-beat frame, last on beat 545 -> err_long_o pulse at beat 540; beats 541-545 accepted and dropped; count unchanged; next good frame count=1.
5. reset_n low at beat 300 of a frame, with one frame already FULL -> all outputs 0 during reset; after release frame_avail_o=0 and count=0; a fresh frame completes normally.
6. frame_done_i asserted in the same cycle as the final beat into the other bank, with both banks otherwise full -> avail stays 1 (new rbank); ready stays 1; rd_req_i in that cycle returns the old frame's data.

Source files
------------

// File: rtl/tart_vis_pkg.sv
// tart_vis_pkg
//   Shared definitions for the visibility frame receiver: default stream
//   geometry, helpers that derive frame size and address width, and the
//   receiver state encoding.
package tart_vis_pkg;

    localparam int VIS_ACCUM = 36;  // bits per real/imag visibility
    localparam int VIS_CORES = 18;  // correlator cores per frame slice
    localparam int VIS_TRATE = 30;  // time-multiplexing rate
    localparam int VIS_FBITS = 16;  // good-frame counter width

    // Beats in one complete frame.
    function automatic int vis_total(input int cores, input int trate);
        return cores * trate;
    endfunction

    // Address width needed to index 'depth' entries (at least 1 bit).
    function automatic int vis_abits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // RX_FILL: storing beats of a frame; RX_DROP: discarding an overlong frame.
    typedef enum logic {
        RX_FILL = 1'b0,
        RX_DROP = 1'b1
    } rx_state_t;

endpackage

// File: rtl/vis_bank_ram.sv
// vis_bank_ram
//   Two-bank simple dual-port RAM holding one frame per bank. Bank 1 starts
//   at entry DEPTH/2. Synchronous write, registered one-cycle read whose
//   output holds when rd_en is low and clears on reset.
// Ports:
//   vis_clock, reset_n      clock, synchronous active-low reset (read reg only)
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr           read request
//   rd_data                 registered read data
module vis_bank_ram #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 1080,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             vis_clock,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge vis_clock) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge vis_clock) begin
        if (!reset_n)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/vis_frame_receiver.sv
// vis_frame_receiver
//   AXI4-Stream sink for correlator visibilities. Captures frames of TOTAL
//   beats into a two-bank buffer, flags short/long frames, and exposes the
//   oldest complete frame to a host reader with a release handshake.
// Ports:
//   vis_clock, reset_n          clock, synchronous active-low reset
//   s_revis_i/s_imvis_i         stream data (real/imag)
//   s_valid_i/s_last_i          stream valid / end of frame
//   s_ready_o                   registered ready (back-pressure when both banks full)
//   rd_req_i/rd_addr_i          host read strobe and visibility index
//   rd_revis_o/rd_imvis_o       read data, one cycle after an accepted request
//   rd_valid_o                  read data valid
//   frame_avail_o               a complete frame is readable
//   frame_done_i                host releases the current read frame
//   frame_count_o               good frames received (wrapping)
//   err_short_o/err_long_o      one-cycle frame length error pulses
module vis_frame_receiver
    import tart_vis_pkg::*;
#(
    parameter int ACCUM = VIS_ACCUM,
    parameter int CORES = VIS_CORES,
    parameter int TRATE = VIS_TRATE,
    parameter int FBITS = VIS_FBITS,
    localparam int TOTAL = vis_total(CORES, TRATE),
    localparam int ABITS = vis_abits(TOTAL)
) (
    input  logic             vis_clock,
    input  logic             reset_n,
    input  logic [ACCUM-1:0] s_revis_i,
    input  logic [ACCUM-1:0] s_imvis_i,
    input  logic             s_valid_i,
    input  logic             s_last_i,
    output logic             s_ready_o,
    input  logic             rd_req_i,
    input  logic [ABITS-1:0] rd_addr_i,
    output logic [ACCUM-1:0] rd_revis_o,
    output logic [ACCUM-1:0] rd_imvis_o,
    output logic             rd_valid_o,
    output logic             frame_avail_o,
    input  logic             frame_done_i,
    output logic [FBITS-1:0] frame_count_o,
    output logic             err_short_o,
    output logic             err_long_o
);

    localparam int RAW = vis_abits(2 * TOTAL);
    localparam logic [ABITS-1:0] LAST_ADDR = ABITS'(TOTAL - 1);

    rx_state_t        state;
    logic [1:0]       full, full_nxt;
    logic             wbank, rbank, wbank_nxt, rbank_nxt;
    logic [ABITS-1:0] waddr;
    logic             accept, at_end, frame_ok, release_rd, wr_en, rd_en;
    logic [RAW-1:0]   ram_waddr, ram_raddr;
    logic [2*ACCUM-1:0] ram_q;

    always_comb begin
        accept     = s_valid_i & s_ready_o;
        at_end     = (waddr == LAST_ADDR);
        frame_ok   = accept && (state == RX_FILL) && at_end && s_last_i;
        // Store only mid-frame beats without last, or the final beat with last;
        // mismatched beats belong to a frame that is about to be discarded.
        wr_en      = accept && (state == RX_FILL) && (at_end == s_last_i);
        release_rd = frame_done_i & full[rbank];
        // Read uses the pre-release rbank, so a same-cycle release still
        // returns data from the frame being released.
        rd_en      = rd_req_i & full[rbank] & (rd_addr_i < ABITS'(TOTAL));
        full_nxt   = full;
        if (frame_ok)
            full_nxt[wbank] = 1'b1;
        if (release_rd)
            full_nxt[rbank] = 1'b0;
        wbank_nxt  = wbank ^ frame_ok;
        rbank_nxt  = rbank ^ release_rd;
        ram_waddr  = wbank ? RAW'(TOTAL) + RAW'(waddr)     : RAW'(waddr);
        ram_raddr  = rbank ? RAW'(TOTAL) + RAW'(rd_addr_i) : RAW'(rd_addr_i);
    end

    always_ff @(posedge vis_clock) begin
        if (!reset_n) begin
            state         <= RX_FILL;
            full          <= '0;
            wbank         <= 1'b0;
            rbank         <= 1'b0;
            waddr         <= '0;
            s_ready_o     <= 1'b0;
            frame_avail_o <= 1'b0;
            rd_valid_o    <= 1'b0;
            err_short_o   <= 1'b0;
            err_long_o    <= 1'b0;
            frame_count_o <= '0;
        end else begin
            full          <= full_nxt;
            wbank         <= wbank_nxt;
            rbank         <= rbank_nxt;
            // Ready looks at next-state bank occupancy so completing into one
            // bank while the other is free costs no bubble.
            s_ready_o     <= ~full_nxt[wbank_nxt];
            frame_avail_o <= full_nxt[rbank_nxt];
            rd_valid_o    <= rd_en;
            err_short_o   <= 1'b0;
            err_long_o    <= 1'b0;
            if (accept) begin
                case (state)
                    RX_FILL: begin
                        if (s_last_i) begin
                            waddr <= '0;
                            if (at_end)
                                frame_count_o <= frame_count_o + FBITS'(1);
                            else
                                err_short_o <= 1'b1;
                        end else if (at_end) begin
                            // Frame overran: hold waddr and swallow beats until last.
                            err_long_o <= 1'b1;
                            state      <= RX_DROP;
                        end else begin
                            waddr <= waddr + ABITS'(1);
                        end
                    end
                    RX_DROP: begin
                        if (s_last_i) begin
                            waddr <= '0;
                            state <= RX_FILL;
                        end
                    end
                    default: state <= RX_FILL;
                endcase
            end
        end
    end

    vis_bank_ram #(
        .WIDTH (2 * ACCUM),
        .DEPTH (2 * TOTAL)
    ) u_ram (
        .vis_clock (vis_clock),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (ram_waddr),
        .wr_data   ({s_revis_i, s_imvis_i}),
        .rd_en     (rd_en),
        .rd_addr   (ram_raddr),
        .rd_data   (ram_q)
    );

    assign rd_revis_o = ram_q[2*ACCUM-1:ACCUM];
    assign rd_imvis_o = ram_q[ACCUM-1:0];

endmodule

// File: tb/tb_vis_frame_receiver.sv
// tb_vis_frame_receiver
//   Directed bench for vis_frame_receiver. A transaction-level model (queue
//   of completed frame ids plus a sparse data store) predicts every output
//   and is compared each cycle; directed literal checks pin the model.
module tb_vis_frame_receiver;

    localparam int ACCUM = 36;
    localparam int TOTAL = 540;
    localparam int ABITS = 10;
    localparam int FBITS = 16;

    logic             vis_clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [ACCUM-1:0] s_revis_i = '0;
    logic [ACCUM-1:0] s_imvis_i = '0;
    logic             s_valid_i = 1'b0;
    logic             s_last_i = 1'b0;
    logic             s_ready_o;
    logic             rd_req_i = 1'b0;
    logic [ABITS-1:0] rd_addr_i = '0;
    logic [ACCUM-1:0] rd_revis_o, rd_imvis_o;
    logic             rd_valid_o, frame_avail_o;
    logic             frame_done_i = 1'b0;
    logic [FBITS-1:0] frame_count_o;
    logic             err_short_o, err_long_o;

    int errors = 0;
    int checks = 0;
    int short_seen = 0;
    int long_seen = 0;

    always #5 vis_clock = ~vis_clock;

    vis_frame_receiver dut (
        .vis_clock     (vis_clock),
        .reset_n       (reset_n),
        .s_revis_i     (s_revis_i),
        .s_imvis_i     (s_imvis_i),
        .s_valid_i     (s_valid_i),
        .s_last_i      (s_last_i),
        .s_ready_o     (s_ready_o),
        .rd_req_i      (rd_req_i),
        .rd_addr_i     (rd_addr_i),
        .rd_revis_o    (rd_revis_o),
        .rd_imvis_o    (rd_imvis_o),
        .rd_valid_o    (rd_valid_o),
        .frame_avail_o (frame_avail_o),
        .frame_done_i  (frame_done_i),
        .frame_count_o (frame_count_o),
        .err_short_o   (err_short_o),
        .err_long_o    (err_long_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [2*ACCUM-1:0] fmem [int];   // key = frame_id*1024 + index
    int               stored[$];      // completed frame ids, oldest first
    int               cur_seq = 0;
    int               cnt = 0;
    bit               drop = 0;
    bit               m_ready = 0, m_es = 0, m_el = 0, m_rv = 0;
    logic [FBITS-1:0] m_count = '0;
    logic [ACCUM-1:0] m_re = '0, m_im = '0;

    always @(posedge vis_clock) begin : model
        bit acc;
        bit rel;
        if (!reset_n) begin
            stored.delete();
            cnt = 0; drop = 0; cur_seq++;
            m_ready = 0; m_es = 0; m_el = 0; m_rv = 0;
            m_count = '0; m_re = '0; m_im = '0;
        end else begin
            acc  = s_valid_i && m_ready;
            m_es = 0;
            m_el = 0;
            m_rv = rd_req_i && (stored.size() > 0) && (rd_addr_i < TOTAL);
            if (m_rv)
                {m_re, m_im} = fmem[stored[0]*1024 + int'(rd_addr_i)];
            rel = frame_done_i && (stored.size() > 0);
            if (rel)
                void'(stored.pop_front());
            if (acc) begin
                if (drop) begin
                    if (s_last_i) begin
                        drop = 0; cnt = 0; cur_seq++;
                    end
                end else begin
                    fmem[cur_seq*1024 + cnt] = {s_revis_i, s_imvis_i};
                    if (s_last_i) begin
                        if (cnt == TOTAL-1) begin
                            stored.push_back(cur_seq);
                            m_count++;
                        end else begin
                            m_es = 1;
                        end
                        cur_seq++;
                        cnt = 0;
                    end else if (cnt == TOTAL-1) begin
                        m_el = 1;
                        drop = 1;
                    end else begin
                        cnt++;
                    end
                end
            end
            m_ready = stored.size() < 2;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge vis_clock) begin
        chk("cmp_ready", s_ready_o, m_ready);
        chk("cmp_avail", frame_avail_o, stored.size() > 0);
        chk("cmp_count", frame_count_o, m_count);
        chk("cmp_err_short", err_short_o, m_es);
        chk("cmp_err_long", err_long_o, m_el);
        chk("cmp_rd_valid", rd_valid_o, m_rv);
        chk("cmp_rd_re", rd_revis_o, m_re);
        chk("cmp_rd_im", rd_imvis_o, m_im);
    end

    // Pulse counters sample the value held during the cycle just ended.
    always @(posedge vis_clock) begin
        if (err_short_o === 1'b1) short_seen++;
        if (err_long_o === 1'b1) long_seen++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_beat(input int v, input bit last);
        int guard;
        bit r;
        guard = 0;
        s_valid_i = 1'b1;
        s_last_i  = last;
        s_revis_i = ACCUM'(v);
        s_imvis_i = ACCUM'(-v);
        forever begin
            r = s_ready_o;
            @(negedge vis_clock);
            if (r) break;
            guard++;
            if (guard > 3000) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: beat %0d not accepted, required acceptance", v);
                break;
            end
        end
    endtask

    task automatic send_frame(input int base, input int n);
        for (int i = 0; i < n; i++)
            send_beat(base + i, i == n-1);
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic do_read(input int addr, input int v);
        logic [ACCUM-1:0] er, ei;
        er = ACCUM'(v);
        ei = ACCUM'(-v);
        rd_req_i  = 1'b1;
        rd_addr_i = ABITS'(addr);
        @(negedge vis_clock);
        rd_req_i = 1'b0;
        chk("rd_valid", rd_valid_o, 1);
        chk("rd_revis", rd_revis_o, er);
        chk("rd_imvis", rd_imvis_o, ei);
    endtask

    task automatic release_frame();
        frame_done_i = 1'b1;
        @(negedge vis_clock);
        frame_done_i = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int s0, l0;
        logic [ACCUM-1:0] ev;

        // Reset state
        repeat (3) @(negedge vis_clock);
        chk("rst_ready", s_ready_o, 0);
        chk("rst_avail", frame_avail_o, 0);
        chk("rst_count", frame_count_o, 0);
        chk("rst_rd_valid", rd_valid_o, 0);
        chk("rst_rd_re", rd_revis_o, 0);
        reset_n = 1'b1;
        @(negedge vis_clock);
        chk("ready_after_rst", s_ready_o, 1);

        // 1: single frame, read index 5
        send_frame(0, TOTAL);
        chk("t1_avail", frame_avail_o, 1);
        chk("t1_count", frame_count_o, 1);
        do_read(5, 5);
        release_frame();
        chk("t1_released", frame_avail_o, 0);

        // 2: three frames back to back with back-pressure
        send_frame(1000, TOTAL);
        send_frame(2000, TOTAL);
        chk("t2_count", frame_count_o, 3);
        chk("t2_ready_full", s_ready_o, 0);
        repeat (2) @(negedge vis_clock);
        chk("t2_ready_held", s_ready_o, 0);
        release_frame();
        chk("t2_ready_after_rel", s_ready_o, 1);
        chk("t2_avail", frame_avail_o, 1);
        send_frame(3000, TOTAL);
        chk("t2_count3", frame_count_o, 4);
        do_read(7, 2007);
        release_frame();
        do_read(0, 3000);
        rd_req_i  = 1'b1;
        rd_addr_i = ABITS'(TOTAL);
        @(negedge vis_clock);
        rd_req_i = 1'b0;
        ev = ACCUM'(3000);
        chk("t2_oob_valid", rd_valid_o, 0);
        chk("t2_oob_hold", rd_revis_o, ev);
        do_read(TOTAL-1, 3000 + TOTAL - 1);
        release_frame();
        chk("t2_empty", frame_avail_o, 0);

        // 3: short frame then a good one
        s0 = short_seen;
        send_frame(4000, 100);
        chk("t3_short_pulse", err_short_o, 1);
        @(negedge vis_clock);
        chk("t3_short_end", err_short_o, 0);
        chk("t3_short_once", short_seen - s0, 1);
        chk("t3_avail", frame_avail_o, 0);
        chk("t3_count", frame_count_o, 4);
        send_frame(5000, TOTAL);
        chk("t3_count_good", frame_count_o, 5);
        do_read(0, 5000);
        release_frame();

        // 4: overlong frame then a good one
        l0 = long_seen;
        send_frame(6000, TOTAL + 5);
        @(negedge vis_clock);
        chk("t4_long_once", long_seen - l0, 1);
        chk("t4_count", frame_count_o, 5);
        chk("t4_avail", frame_avail_o, 0);
        send_frame(7000, TOTAL);
        chk("t4_count_good", frame_count_o, 6);
        chk("t4_avail_good", frame_avail_o, 1);

        // 5: reset mid-frame with one frame already held
        for (int i = 0; i < 300; i++)
            send_beat(8000 + i, 1'b0);
        s_valid_i = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge vis_clock);
        chk("t5_rst_ready", s_ready_o, 0);
        chk("t5_rst_avail", frame_avail_o, 0);
        chk("t5_rst_count", frame_count_o, 0);
        chk("t5_rst_rd_re", rd_revis_o, 0);
        chk("t5_rst_err", {err_short_o, err_long_o, rd_valid_o}, 0);
        reset_n = 1'b1;
        @(negedge vis_clock);
        chk("t5_avail", frame_avail_o, 0);
        chk("t5_count", frame_count_o, 0);
        send_frame(9000, TOTAL);
        chk("t5_count_fresh", frame_count_o, 1);
        chk("t5_avail_fresh", frame_avail_o, 1);

        // 6: final beat into other bank coincides with release and a read
        for (int i = 0; i < TOTAL-1; i++)
            send_beat(10000 + i, 1'b0);
        chk("t6_ready_pre", s_ready_o, 1);
        s_valid_i    = 1'b1;
        s_last_i     = 1'b1;
        s_revis_i    = ACCUM'(10000 + TOTAL - 1);
        s_imvis_i    = ACCUM'(-(10000 + TOTAL - 1));
        frame_done_i = 1'b1;
        rd_req_i     = 1'b1;
        rd_addr_i    = ABITS'(3);
        @(negedge vis_clock);
        s_valid_i    = 1'b0;
        s_last_i     = 1'b0;
        frame_done_i = 1'b0;
        rd_req_i     = 1'b0;
        ev = ACCUM'(9003);
        chk("t6_avail", frame_avail_o, 1);
        chk("t6_ready", s_ready_o, 1);
        chk("t6_rd_valid", rd_valid_o, 1);
        chk("t6_rd_old", rd_revis_o, ev);
        chk("t6_count", frame_count_o, 2);
        do_read(3, 10003);

        repeat (2) @(negedge vis_clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
